// File: rtl/spi_3wire_sequencer.sv
// Autonomous master for the SPI 3-wire command core. After reset it waits,
// writes the init table to the sensor register by register, then
// periodically burst-reads six data bytes and publishes them as x/y/z
// samples. A watchdog bounds every wait on the core's handshake.
module spi_3wire_sequencer #(
  parameter int          INIT_LEN       = 4,
  parameter int          STARTUP_CYCLES = 1000,
  parameter int          POLL_CYCLES    = 50000,
  parameter logic [7:0]  DATA_ADDR      = 8'h32,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [3:0]  tbl_index,
  input  logic [15:0] tbl_entry,
  output logic        cmd_start,
  input  logic        cmd_done,
  output logic [7:0]  reg_addr,
  output logic        reg_rw,
  output logic [7:0]  reg_rx_num,
  output logic        fifo_clear,
  output logic        fifo_write,
  output logic [7:0]  fifo_writedata,
  output logic        fifo_read_ack,
  input  logic [7:0]  fifo_readdata,
  output logic [15:0] x_out,
  output logic [15:0] y_out,
  output logic [15:0] z_out,
  output logic        sample_valid,
  output logic        init_done,
  output logic        busy,
  output logic        error
);

  localparam int SU_W = $clog2(STARTUP_CYCLES + 1);
  localparam int PL_W = $clog2(POLL_CYCLES + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [SU_W-1:0] SU_LAST  = SU_W'(STARTUP_CYCLES - 1);
  localparam logic [PL_W-1:0] PL_LAST  = PL_W'(POLL_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      IDX_LAST = 4'(INIT_LEN - 1);
  localparam logic [2:0]      POP_LAST = 3'd5;

  typedef enum logic [3:0] {
    S_STARTUP,
    S_INIT_CLR,
    S_INIT_LOAD,
    S_ACK,
    S_DONE,
    S_POLL_WAIT,
    S_RD_CLR,
    S_RD_POP,
    S_PUBLISH
  } state_t;

  state_t          state;
  logic [SU_W-1:0] su_cnt;
  logic [PL_W-1:0] poll_cnt;
  logic [TO_W-1:0] wdog_cnt;
  logic [2:0]      pop_k;
  logic [7:0]      rx_byte [0:4];

  // Sequencer FSM with all outputs registered alongside the state.
  // NOTE: every sequential assignment is non-blocking so all registers in
  // this block update together from pre-edge values; a later assignment in
  // the same cycle (e.g. strobe defaults below) simply overrides an earlier one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_STARTUP;
      su_cnt         <= '0;
      poll_cnt       <= '0;
      wdog_cnt       <= '0;
      pop_k          <= '0;
      tbl_index      <= '0;
      cmd_start      <= 1'b0;
      reg_addr       <= '0;
      reg_rw         <= 1'b0;
      reg_rx_num     <= '0;
      fifo_clear     <= 1'b0;
      fifo_write     <= 1'b0;
      fifo_writedata <= '0;
      fifo_read_ack  <= 1'b0;
      x_out          <= '0;
      y_out          <= '0;
      z_out          <= '0;
      sample_valid   <= 1'b0;
      init_done      <= 1'b0;
      busy           <= 1'b0;
      error          <= 1'b0;
      // NOTE: the byte slots are a small register array, not RAM, so they
      // are reset like any other flop; this keeps the block free of X after reset.
      for (int i = 0; i < 5; i++) rx_byte[i] <= '0;
    end else begin
      // Single-cycle strobes default low; the state that needs one raises it.
      fifo_clear    <= 1'b0;
      fifo_write    <= 1'b0;
      fifo_read_ack <= 1'b0;
      sample_valid  <= 1'b0;
      // The poll counter runs from the start of each read and saturates.
      if (poll_cnt != PL_LAST) poll_cnt <= poll_cnt + 1'b1;

      case (state)
        S_STARTUP: begin
          if (su_cnt == SU_LAST) begin
            su_cnt     <= '0;
            tbl_index  <= '0;
            fifo_clear <= 1'b1;
            state      <= S_INIT_CLR;
          end else begin
            su_cnt <= su_cnt + 1'b1;
          end
        end

        S_INIT_CLR: begin
          fifo_write     <= 1'b1;
          fifo_writedata <= tbl_entry[7:0];
          reg_addr       <= tbl_entry[15:8];
          reg_rw         <= 1'b0;
          reg_rx_num     <= '0;
          state          <= S_INIT_LOAD;
        end

        S_INIT_LOAD: begin
          cmd_start <= 1'b1;
          busy      <= 1'b1;
          wdog_cnt  <= '0;
          state     <= S_ACK;
        end

        S_ACK, S_DONE: begin
          if (wdog_cnt == TO_LAST) begin
            // Core never completed the handshake: abandon the command.
            cmd_start <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b1;
            wdog_cnt  <= '0;
            if (init_done) begin
              state <= S_POLL_WAIT;
            end else begin
              su_cnt    <= '0;
              tbl_index <= '0;
              state     <= S_STARTUP;
            end
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (state == S_ACK) begin
              // Only a low cmd_done proves the core accepted the command.
              if (!cmd_done) begin
                cmd_start <= 1'b0;
                state     <= S_DONE;
              end
            end else if (cmd_done) begin
              busy <= 1'b0;
              if (init_done) begin
                fifo_read_ack <= 1'b1;
                pop_k         <= '0;
                state         <= S_RD_POP;
              end else if (tbl_index == IDX_LAST) begin
                init_done <= 1'b1;
                poll_cnt  <= PL_LAST;   // first read starts right away
                state     <= S_POLL_WAIT;
              end else begin
                tbl_index  <= tbl_index + 1'b1;
                fifo_clear <= 1'b1;
                state      <= S_INIT_CLR;
              end
            end
          end
        end

        S_POLL_WAIT: begin
          if (poll_cnt == PL_LAST && enable) begin
            poll_cnt   <= '0;
            fifo_clear <= 1'b1;
            state      <= S_RD_CLR;
          end
        end

        S_RD_CLR: begin
          reg_addr   <= DATA_ADDR;
          reg_rw     <= 1'b1;
          reg_rx_num <= 8'd6;
          cmd_start  <= 1'b1;
          busy       <= 1'b1;
          wdog_cnt   <= '0;
          state      <= S_ACK;
        end

        S_RD_POP: begin
          if (pop_k == POP_LAST) begin
            // Last byte goes straight into z so all three update together.
            x_out        <= {rx_byte[1], rx_byte[0]};
            y_out        <= {rx_byte[3], rx_byte[2]};
            z_out        <= {fifo_readdata, rx_byte[4]};
            sample_valid <= 1'b1;
            state        <= S_PUBLISH;
          end else begin
            rx_byte[pop_k] <= fifo_readdata;
            pop_k          <= pop_k + 1'b1;
            fifo_read_ack  <= 1'b1;
          end
        end

        S_PUBLISH: begin
          state <= S_POLL_WAIT;
        end

        default: state <= S_STARTUP;
      endcase
    end
  end

endmodule
